// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: sync + glitch filter + 11-bit frame decode; optional make-code-only output under `PS2_BREAK_FILTER_EN.
// Strobe one CLOCK_50 cycle after the filtered stop-bit fall; no backpressure (receive only, line never driven).
`timescale 1ns/1ps
module ps2_rx_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic [FW-1:0]          filt_cnt;
  logic                   clk_filt, clk_filt_d;
  logic                   fall;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [7:0]  data_n;
  logic        en_n, err_n;
  logic        frame_ok;
`ifdef PS2_BREAK_FILTER_EN
  logic        brk, brk_n;
`endif

  // Idle-high line: every synchroniser and filter stage presets to 1.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_filt <= clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign frame_ok = dat_s & ((^shift) ^ par);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    to_cnt_n  = to_cnt;
    data_n    = received_data;
    en_n      = 1'b0;
    err_n     = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_n     = brk;
`endif
    // A fall takes priority over a coincident timeout expiry.
    if (fall) begin
      to_cnt_n = '0;
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
            shift_n   = 8'h00;
          end
        end
        DATA: begin
          shift_n[bit_cnt] = dat_s;
          bit_cnt_n        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
            if (shift == 8'hF0) begin
              brk_n = 1'b1;
            end else if (brk) begin
              brk_n = 1'b0;
            end else begin
              data_n = shift;
              en_n   = 1'b1;
            end
`else
            data_n = shift;
            en_n   = 1'b1;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n  = IDLE;
        to_cnt_n = '0;
        err_n    = 1'b1;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end else begin
      to_cnt_n = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      shift            <= 8'h00;
      par              <= 1'b0;
      to_cnt           <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state            <= state_n;
      bit_cnt          <= bit_cnt_n;
      shift            <= shift_n;
      par              <= par_n;
      to_cnt           <= to_cnt_n;
      received_data    <= data_n;
      received_data_en <= en_n;
      frame_error      <= err_n;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) brk <= 1'b0;
    else         brk <= brk_n;
  end
`endif

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Scoreboard bench for ps2_rx_decoder: frames are driven bit by bit, expected events queued, and outputs checked as they appear.
`timescale 1ns/1ps
module tb_ps2_rx_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TMO  = 600;
  localparam int HALF = 40;
  localparam int LAT  = SYNC + FILT + 1;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;

  ps2_rx_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50        (CLOCK_50),
    .Resetn          (Resetn),
    .PS2_CLK         (ps2_clk),
    .PS2_DAT         (ps2_dat),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .frame_error     (frame_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit         err;
    logic [7:0] dat;
    int         dly;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         last_fall = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  bit         brk_model = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       prev_en = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (Resetn && (received_data_en || frame_error)) begin
      chk("strobe_err_excl", 32'(received_data_en & frame_error), 0);
      if (received_data_en) chk("strobe_width", 32'(prev_en), 0);
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'({received_data_en, frame_error}), 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 32'(frame_error), 32'(e.err));
        if (!e.err) chk("data", 32'(received_data), 32'(e.dat));
        chk("latency", 32'(cyc - last_fall), 32'(e.dly));
      end
    end
    prev_en = received_data_en;
  end

  task automatic bit_out(input logic b);
    @(negedge CLOCK_50) ps2_dat = b;
    repeat (HALF) @(negedge CLOCK_50);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge CLOCK_50);
    ps2_clk = 1'b1;
  endtask

  task automatic push_exp(input bit err, input logic [7:0] d, input int dly);
    exp_t x;
    x.err = err;
    x.dat = d;
    x.dly = dly;
    sb.push_back(x);
  endtask

  task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(p);
    if (bad_par || bad_stop) begin
      push_exp(1'b1, 8'h00, LAT);
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (d == 8'hF0) brk_model = 1'b1;
      else if (brk_model) brk_model = 1'b0;
      else begin
        push_exp(1'b0, d, LAT);
        last_data = d;
      end
`else
      push_exp(1'b0, d, LAT);
      last_data = d;
`endif
    end
    bit_out(!bad_stop);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 0);
    repeat (20) @(negedge CLOCK_50);
  endtask

  initial begin
    logic [7:0] part;
    part = 8'h29;
    repeat (5) @(negedge CLOCK_50);
    chk("rst_data", 32'(received_data), 0);
    chk("rst_en", 32'(received_data_en), 0);
    chk("rst_err", 32'(frame_error), 0);
    Resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    frame(8'h23, 1'b0, 1'b0);
    drain(300);
    chk("hold_23", 32'(received_data), 32'h23);

    frame(8'h1C, 1'b1, 1'b0);
    drain(300);
    chk("hold_after_parity_err", 32'(received_data), 32'h23);

    frame(8'h29, 1'b0, 1'b1);
    drain(300);
    chk("hold_after_stop_err", 32'(received_data), 32'h23);

    // Start + 5 data bits, then the clock stays high until the timeout fires.
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(part[i]);
    push_exp(1'b1, 8'h00, LAT + TMO);
    drain(TMO + 300);
    chk("hold_after_timeout", 32'(received_data), 32'h23);

    frame(8'h29, 1'b0, 1'b0);
    drain(300);
    chk("data_29", 32'(received_data), 32'h29);

    // Short low glitch, then a clean fall with data high: both must be ignored.
    @(negedge CLOCK_50);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    ps2_clk = 1'b1;
    repeat (60) @(negedge CLOCK_50);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge CLOCK_50);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge CLOCK_50);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge CLOCK_50);
    chk("glitch_no_event", 32'(sb.size()), 0);

    frame(8'h5A, 1'b0, 1'b0);
    drain(300);
    chk("data_5a", 32'(received_data), 32'h5A);

    frame(8'hF0, 1'b0, 1'b0);
    frame(8'h1C, 1'b0, 1'b0);
    drain(300);
    chk("data_after_break_seq", 32'(received_data), 32'(last_data));
    frame(8'h23, 1'b0, 1'b0);
    drain(300);
    chk("data_after_23", 32'(received_data), 32'h23);

    // Reset in the middle of an F0 frame, after its 4th data bit.
    part = 8'hF0;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(part[i]);
    @(negedge CLOCK_50) Resetn = 1'b0;
    brk_model = 1'b0;
    last_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("midrst_data", 32'(received_data), 0);
      chk("midrst_en", 32'(received_data_en), 0);
      chk("midrst_err", 32'(frame_error), 0);
    end
    Resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    frame(8'h1C, 1'b0, 1'b0);
    drain(300);
    chk("data_after_reset", 32'(received_data), 32'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected completion before 5 ms");
    $fatal(1);
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
- PS/2 keyboard receiver. Turns the raw PS2_CLK/PS2_DAT lines into the byte stream that the Connect 4 game logic consumes (received_data / received_data_en).
- Decodes device-to-host frames: 11 bits, sampled on PS2_CLK falling edges.
- Produces a one-cycle strobe per valid byte and flags malformed frames.
- Sits between the board's PS/2 pins and the game FSM. Receive only: the line is never driven.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising PS2_CLK and PS2_DAT into CLOCK_50. Minimum 2.
- FILTER_LEN, 8: consecutive CLOCK_50 cycles the synchronised PS2_CLK must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles with no filtered falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- Resetn  input  1  reset, asynchronous, active-low.
- PS2_CLK  input  1  raw PS/2 clock from the device, asynchronous.
- PS2_DAT  input  1  raw PS/2 data from the device, asynchronous.
- received_data  output  8  last accepted scan-code byte; held between strobes.
- received_data_en  output  1  one-cycle strobe; received_data is valid in the same cycle.
- frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.

Behaviour:
- Reset, asynchronous:
  - received_data=8'h00, received_data_en=0, frame_error=0.
  - State=IDLE, bit counter=0, shift register=0, timeout counter=0.
  - Filtered clock=1; synchroniser and filter stages preset to 1 (idle-high line).
- Input path:
  - Both inputs pass through SYNC_STAGES flops.
  - The filter counter reloads whenever synchronised PS2_CLK equals the filtered clock.
  - After FILTER_LEN consecutive differing samples, the filtered clock takes the new level.
  - fall = filtered clock 1->0 this cycle.
  - The data bit is the synchronised PS2_DAT sampled in the fall cycle.
- FSM, advancing only on fall unless noted:
  - IDLE: bit=0 -> DATA with bit counter=0. bit=1 -> stay in IDLE (spurious edge ignored).
  - DATA: shift the bit in LSB first (data[counter]=bit); counter+1. After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP:
    - Valid frame: stop bit=1 AND (XOR of 8 data bits ^ parity bit)=1, i.e. odd parity. Next cycle: received_data<=byte, received_data_en=1 for exactly one cycle.
    - Otherwise: frame_error=1 for one cycle; received_data unchanged.
    - Either way -> IDLE.
- Latency: received_data_en rises exactly one CLOCK_50 cycle after the fall cycle of the stop bit.
- Timeout:
  - Counter is 0 in IDLE and clears on every fall.
  - In any other state it increments each cycle.
  - Reaching TIMEOUT_CYCLES: -> IDLE, partial byte discarded, frame_error pulses one cycle, no strobe.
  - Width is $clog2(TIMEOUT_CYCLES+1); no wrap.
- Simultaneous events: if timeout expiry and fall coincide, fall wins (counter clears, bit processed).
- Minimum gap: back-to-back frames need no idle cycles between them beyond the protocol's own; a start bit may follow the stop bit immediately.
- Reset mid-frame: partial frame discarded. The next start bit decodes a fresh frame.
- Strobe and error exclusivity: received_data_en and frame_error are never high in the same cycle.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A valid byte 8'hF0 is not strobed; it sets an internal break_pending flag.
  - The next valid byte is also not strobed; it clears break_pending.
  - received_data does not update for suppressed bytes.
  - 8'hE0 passes through unchanged.
  - frame_error does not clear break_pending; reset does.
  - Effect: the game sees only make codes.
- Undefined: every valid byte, including F0, is strobed; no break_pending state.

Test Plan:
- Frame 0x23 (data 1,1,0,0,0,1,0,0, parity 0, stop 1) at 10 kHz PS2_CLK -> received_data=8'h23, received_data_en high exactly 1 cycle, 1 cycle after the stop falling edge; frame_error=0.
- After 0x23, frame 0x1C with parity=1 (bad) -> frame_error one-cycle pulse, no strobe, received_data stays 8'h23. Frame 0x29 with stop=0 -> frame_error pulse, no strobe.
- Start bit plus 5 data bits, then clock held high -> frame_error pulse at TIMEOUT_CYCLES after the last fall. Following clean frame 0x29 -> strobe with 8'h29.
- Glitch rejection:
  - 3-cycle low pulse on PS2_CLK with PS2_DAT=0 in IDLE -> no state change, no outputs.
  - PS2_DAT=1 at a clean falling edge in IDLE -> stays IDLE.
- Resetn asserted after the 4th data bit of 0xF0, then released, then full frame 0x1C -> strobe with 8'h1C. All outputs 0 during reset.
- Frames F0 then 1C:
  - With PS2_BREAK_FILTER_EN: no strobes, received_data unchanged. A following 0x23 strobes 8'h23.
  - Without: two strobes, 8'hF0 then 8'h1C.
